mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 163 ++++++++++++++++
 tb/tb_mem_responder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: single-port 32-bit word memory behind a MAR/MDR style
// request interface, with a programmable number of wait cycles per access.
//
// Parameters
//   ADDR_BITS  word-address width; depth is 2**ADDR_BITS words (1..31)
//   LATENCY    wait cycles inserted before each access (0..15)
//
// Ports
//   clk        system clock, rising-edge
//   reset_n    asynchronous active-low reset
//   mar_addr   word address of the request
//   mdr_wdata  write data of the request
//   read       level read request
//   write      level write request
//   rdata      registered read data, updated only by completed reads
//   mem_ready  one-cycle completion pulse (read or write)
//   busy       high while a request is in flight (WAIT or ACCESS)
//   err        one-cycle pulse for a rejected request
//
// Timing: a request sampled at edge N completes at edge N+LATENCY+1. The
// mem_ready pulse and the new rdata both become visible right after that
// edge, so the requester sees them together in the same cycle.

module mem_responder #(
  parameter int ADDR_BITS = 9,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] mar_addr,
  input  logic [31:0] mdr_wdata,
  input  logic        read,
  input  logic        write,
  output logic [31:0] rdata,
  output logic        mem_ready,
  output logic        busy,
  output logic        err
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS
  } state_e;

  state_e                 state_q,  state_d;
  logic [3:0]             cnt_q,    cnt_d;
  logic [ADDR_BITS-1:0]   addr_q,   addr_d;
  logic [31:0]            wdata_q,  wdata_d;
  logic                   op_wr_q,  op_wr_d;
  logic [31:0]            rdata_q,  rdata_d;
  logic                   ready_q,  ready_d;
  logic                   err_q,    err_d;
  logic                   mem_we;
  logic                   addr_ok;

  logic [31:0] mem_array [DEPTH];

  // Every address bit above the array range must be zero.
  assign addr_ok = (mar_addr >> ADDR_BITS) == 32'd0;

  // NOTE: every signal gets a default before the case statement so no path
  // leaves a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    op_wr_d = op_wr_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    mem_we  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (read && write) begin
          err_d = 1'b1;
        end else if (read || write) begin
          if (!addr_ok) begin
            err_d = 1'b1;
          end else begin
            // Capture the whole request so later input changes are ignored.
            addr_d  = mar_addr[ADDR_BITS-1:0];
            wdata_d = mdr_wdata;
            op_wr_d = write;
            if (LATENCY == 0) begin
              state_d = ACCESS;
            end else begin
              state_d = WAIT;
              cnt_d   = LAT_M1;
            end
          end
        end
      end

      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ACCESS;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ACCESS: begin
        // The array write and the rdata load both happen on the edge that
        // leaves ACCESS; an asynchronous reset in this cycle clears state_q
        // first and so suppresses both the write and the mem_ready pulse.
        ready_d = 1'b1;
        state_d = IDLE;
        if (op_wr_q) begin
          mem_we = 1'b1;
        end else begin
          rdata_d = mem_array[addr_q];
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      op_wr_q <= 1'b0;
      rdata_q <= 32'd0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      op_wr_q <= op_wr_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  // NOTE: the array has no reset; its contents survive reset_n and it can map
  // onto plain RAM. Writes are still blocked during reset because mem_we
  // depends on state_q, which reset forces to IDLE.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_array[addr_q] <= wdata_q;
    end
  end

  assign rdata     = rdata_q;
  assign mem_ready = ready_q;
  assign err       = err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with LATENCY=2 driven from a
// vector table plus hand-written multi-cycle sequences, and one instance with
// LATENCY=0 for the zero-wait and held-request behaviour.

module tb_mem_responder;

  localparam int LAT2 = 2;

  logic clk;
  logic reset_n;

  // LATENCY=2 instance
  logic        read2, write2;
  logic [31:0] addr2, wdata2, rdata2;
  logic        rdy2, busy2, err2;

  // LATENCY=0 instance
  logic        read0, write0;
  logic [31:0] addr0, wdata0, rdata0;
  logic        rdy0, busy0, err0;

  int n_checks = 0;
  int n_errors = 0;

  mem_responder #(.ADDR_BITS(9), .LATENCY(LAT2)) dut2 (
    .clk      (clk),
    .reset_n  (reset_n),
    .mar_addr (addr2),
    .mdr_wdata(wdata2),
    .read     (read2),
    .write    (write2),
    .rdata    (rdata2),
    .mem_ready(rdy2),
    .busy     (busy2),
    .err      (err2)
  );

  mem_responder #(.ADDR_BITS(9), .LATENCY(0)) dut0 (
    .clk      (clk),
    .reset_n  (reset_n),
    .mar_addr (addr0),
    .mdr_wdata(wdata0),
    .read     (read0),
    .write    (write0),
    .rdata    (rdata0),
    .mem_ready(rdy0),
    .busy     (busy0),
    .err      (err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Present one request to the LATENCY=2 instance for exactly one sampling
  // edge, then watch (bounded) for mem_ready or err. k counts negedges after
  // the sampling edge; k=0 is the cycle right after it.
  task automatic issue2(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, output int k, output logic got_rdy,
                        output logic got_err, output logic busy_k0);
    @(negedge clk);
    read2 = rd; write2 = wr; addr2 = a; wdata2 = wd;
    @(posedge clk);
    @(negedge clk);
    read2 = 1'b0; write2 = 1'b0;
    busy_k0 = busy2;
    got_rdy = 1'b0;
    got_err = 1'b0;
    k = 0;
    while (k < 20) begin
      if (rdy2 || err2) begin
        got_rdy = rdy2;
        got_err = err2;
        break;
      end
      @(negedge clk);
      k++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int   k;
    logic got_rdy, got_err, b0;
    issue2(v.rd, v.wr, v.addr, v.wdata, k, got_rdy, got_err, b0);
    check({v.name, " busy"}, {31'd0, b0}, {31'd0, !v.exp_err});
    check({v.name, " err"}, {31'd0, got_err}, {31'd0, v.exp_err});
    check({v.name, " ready"}, {31'd0, got_rdy}, {31'd0, !v.exp_err});
    if (v.exp_err) check({v.name, " err_cycle"}, k, 0);
    else           check({v.name, " ready_cycle"}, k, LAT2 + 1);
    check({v.name, " rdata"}, rdata2, v.exp_rdata);
    @(negedge clk);
    check({v.name, " pulse_width"}, {30'd0, rdy2, err2}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // mem_ready and err must never coincide, on either instance.
  always @(negedge clk) begin
    if (reset_n && ((rdy2 && err2) || (rdy0 && err0))) begin
      n_checks++;
      n_errors++;
      $display("FAIL ready_err_overlap: got both high expected exclusive");
    end
  end

  initial begin
    int   k;
    logic got_rdy, got_err, b0;
    vec_t v;
    logic saw_rdy;

    vecs[0]  = '{"wr55_a5",     0, 1, 32'h0000_0055, 32'h0000_00A5, 0, 32'h0000_0000};
    vecs[1]  = '{"rd55",        1, 0, 32'h0000_0055, 32'h0,         0, 32'h0000_00A5};
    vecs[2]  = '{"rdwr_both",   1, 1, 32'h0000_0010, 32'h7777_7777, 1, 32'h0000_00A5};
    vecs[3]  = '{"rd_oob200",   1, 0, 32'h0000_0200, 32'h0,         1, 32'h0000_00A5};
    vecs[4]  = '{"wr_top",      0, 1, 32'h0000_01FF, 32'hDEAD_BEEF, 0, 32'h0000_00A5};
    vecs[5]  = '{"wr_zero",     0, 1, 32'h0000_0000, 32'h0BAD_F00D, 0, 32'h0000_00A5};
    vecs[6]  = '{"rd_top",      1, 0, 32'h0000_01FF, 32'h0,         0, 32'hDEAD_BEEF};
    vecs[7]  = '{"rd_zero",     1, 0, 32'h0000_0000, 32'h0,         0, 32'h0BAD_F00D};
    vecs[8]  = '{"wr_oob_msb",  0, 1, 32'h8000_0000, 32'h5555_5555, 1, 32'h0BAD_F00D};
    vecs[9]  = '{"wr55_new",    0, 1, 32'h0000_0055, 32'h1234_5678, 0, 32'h0BAD_F00D};
    vecs[10] = '{"rd55_new",    1, 0, 32'h0000_0055, 32'h0,         0, 32'h1234_5678};
    vecs[11] = '{"both_oob",    1, 1, 32'h0000_0400, 32'h0,         1, 32'h1234_5678};

    reset_n = 1'b0;
    read2 = 0; write2 = 0; addr2 = 0; wdata2 = 0;
    read0 = 0; write0 = 0; addr0 = 0; wdata0 = 0;

    // Reset state
    #12;
    check("reset rdata2", rdata2, 32'd0);
    check("reset flags2", {29'd0, rdy2, busy2, err2}, 32'd0);
    check("reset rdata0", rdata0, 32'd0);
    check("reset flags0", {29'd0, rdy0, busy0, err0}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Input changes during WAIT are ignored: the read of 0x1FF completes
    // unchanged and the write presented mid-flight never happens.
    @(negedge clk);
    read2 = 1'b1; addr2 = 32'h0000_01FF;
    @(posedge clk);
    @(negedge clk);
    read2 = 1'b0; write2 = 1'b1; addr2 = 32'h0; wdata2 = 32'h1111_1111;
    check("ignore busy", {31'd0, busy2}, 32'd1);
    k = 0;
    while (k < 20 && !rdy2) begin
      @(negedge clk);
      k++;
      if (k == 2) write2 = 1'b0;
    end
    check("ignore ready_cycle", k, LAT2 + 1);
    check("ignore rdata", rdata2, 32'hDEAD_BEEF);
    v = '{"ignore rd_zero", 1, 0, 32'h0, 32'h0, 0, 32'h0BAD_F00D};
    run_vec(v);

    // Reset mid-WAIT aborts the write without a mem_ready pulse and leaves
    // the array untouched.
    v = '{"rst wr3", 0, 1, 32'h3, 32'h0000_1234, 0, 32'h0BAD_F00D};
    run_vec(v);
    @(negedge clk);
    write2 = 1'b1; addr2 = 32'h3; wdata2 = 32'h0000_FFFF;
    @(posedge clk);
    @(negedge clk);
    write2 = 1'b0;
    check("rst inflight busy", {31'd0, busy2}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst async flags", {29'd0, rdy2, busy2, err2}, 32'd0);
    check("rst async rdata", rdata2, 32'd0);
    saw_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rdy2) saw_rdy = 1'b1;
    end
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rdy2) saw_rdy = 1'b1;
    end
    check("rst no ready", {31'd0, saw_rdy}, 32'd0);
    v = '{"rst rd3", 1, 0, 32'h3, 32'h0, 0, 32'h0000_1234};
    run_vec(v);

    // LATENCY=0: write completes one cycle later, then a held read gives
    // one completion every two cycles.
    @(negedge clk);
    write0 = 1'b1; addr0 = 32'h5; wdata0 = 32'h0000_CAFE;
    @(posedge clk);
    @(negedge clk);
    write0 = 1'b0;
    check("lat0 wr k0 ready", {31'd0, rdy0}, 32'd0);
    check("lat0 wr k0 busy", {31'd0, busy0}, 32'd1);
    @(negedge clk);
    check("lat0 wr k1 ready", {31'd0, rdy0}, 32'd1);
    check("lat0 wr k1 rdata", rdata0, 32'd0);
    @(negedge clk);
    read0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("lat0 held k%0d ready", i), {31'd0, rdy0}, {31'd0, (i % 2) == 1});
      if (i == 1) check("lat0 held rdata", rdata0, 32'h0000_CAFE);
      @(negedge clk);
    end
    read0 = 1'b0;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
